mainm_arbiter: RTL and testbench

MAINM_ARBITER -- requirements
Module: mainm_arbiter

---
 rtl/mainm_arbiter_pkg.sv | 23 ++
 rtl/rr_pick.sv | 31 +++
 rtl/mainm_arbiter.sv | 133 +++++++++++++
 tb/tb_mainm_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mainm_arbiter_pkg.sv
// Shared state encoding, bus payload type and constants for the main-memory arbiter.
package mainm_arbiter_pkg;

    localparam int unsigned GID_W  = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // One requester's view of the downstream bus; rd is already masked by we.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              we;
        logic              rd;
    } mem_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick starting after the last owner; a locked last owner wins outright.
module rr_pick
    import mainm_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  lock_i,
    input  logic [GID_W-1:0] last_i,
    output logic [GID_W-1:0] win_o,
    output logic             valid_o
);

    logic [GID_W-1:0] idx;
    logic             found;

    always_comb begin
        win_o   = last_i;
        found   = lock_i[last_i] & req_i[last_i];
        idx     = '0;
        valid_o = |req_i;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = GID_W'((32'(last_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                win_o = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mainm_arbiter.sv
// Arbitrates NREQ requesters onto one memory port: round-robin with lock,
// combinational completion and a bus-error timeout.
module mainm_arbiter
    import mainm_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_d,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ-1:0]        req_rd,
    output logic [DATA_W-1:0]      req_spo,
    output logic [NREQ-1:0]        req_ready,
    output logic [DATA_W-1:0]      mem_a,
    output logic [DATA_W-1:0]      mem_d,
    output logic                   mem_we,
    output logic                   mem_rd,
    input  logic [DATA_W-1:0]      mem_spo,
    input  logic                   mem_ready,
    input  logic [NREQ-1:0]        lock,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [GID_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  req_any;
    logic [GID_W-1:0] pick_win;
    logic             pick_valid;
    mem_req_t         port [NREQ];
    mem_req_t         sel;

    // Unpack the flat buses; both strobes set counts as a write.
    for (genvar i = 0; i < NREQ; i++) begin : g_port
        assign port[i] = {req_a[i*DATA_W +: DATA_W], req_d[i*DATA_W +: DATA_W],
                          req_we[i], req_rd[i] & ~req_we[i]};
    end

    assign req_any  = req_rd | req_we;
    assign sel      = port[grant_q];
    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req_i  (req_any),
        .lock_i (lock),
        .last_i (last_q),
        .win_o  (pick_win),
        .valid_o(pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GID_W'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        req_spo   = '0;
        err       = 1'b0;
        mem_a     = '0;
        mem_d     = '0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_win;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                mem_a  = sel.a;
                mem_d  = sel.d;
                mem_we = sel.we;
                mem_rd = sel.rd;
                if (state_q == ST_WAIT && cnt_q != CNT_TERM) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A real completion beats the terminal count in the same cycle.
                if (mem_ready) begin
                    req_ready = NREQ'(1) << grant_q;
                    req_spo   = mem_spo;
                    last_d    = grant_q;
                    state_d   = ST_IDLE;
                end else if (state_q == ST_WAIT && cnt_q == CNT_TERM) begin
                    req_ready = NREQ'(1) << grant_q;
                    req_spo   = BUS_ERR_DATA;
                    err       = 1'b1;
                    last_d    = grant_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs stay quiet while reset is held so an aborted transfer never completes.
        if (!rst) begin
            req_ready = '0;
            req_spo   = '0;
            err       = 1'b0;
            mem_we    = 1'b0;
            mem_rd    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mainm_arbiter.sv
// Directed and randomised checks of mainm_arbiter against a transaction-level model.
module tb_mainm_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ*32-1:0]   req_a, req_d;
    logic [NREQ-1:0]      req_we, req_rd, lock, req_ready;
    logic [31:0]          req_spo, mem_a, mem_d, mem_spo;
    logic                 mem_we, mem_rd, mem_ready, busy, err;
    logic [1:0]           grant_id;

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 idle), cycles since grant (0 = issue cycle), last completed owner.
    int m_owner, m_age, m_last;
    logic [NREQ-1:0] e_ready;
    logic [31:0]     e_spo, e_a, e_d;
    logic            e_we, e_rd, e_busy, e_err;

    always #5 clk = ~clk;

    mainm_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_d(req_d), .req_we(req_we), .req_rd(req_rd),
        .req_spo(req_spo), .req_ready(req_ready), .mem_a(mem_a), .mem_d(mem_d),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_spo(mem_spo), .mem_ready(mem_ready),
        .lock(lock), .grant_id(grant_id), .busy(busy), .err(err)
    );

    function automatic logic bit_at(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (bit_at(v, i)) return i;
        return -1;
    endfunction

    function automatic int pick_winner();
        logic [NREQ-1:0] r;
        r = req_rd | req_we;
        if (bit_at(lock, m_last) && bit_at(r, m_last)) return m_last;
        for (int k = 1; k <= NREQ; k++) if (bit_at(r, (m_last + k) % NREQ)) return (m_last + k) % NREQ;
        return -1;
    endfunction

    task automatic model_expect();
        e_busy = (m_owner >= 0);
        e_ready = '0; e_spo = '0; e_err = 1'b0; e_a = '0; e_d = '0; e_we = 1'b0; e_rd = 1'b0;
        if (rst && m_owner >= 0) begin
            e_a  = 32'(req_a >> (m_owner * 32));
            e_d  = 32'(req_d >> (m_owner * 32));
            e_we = bit_at(req_we, m_owner);
            e_rd = bit_at(req_rd, m_owner) && !e_we;
            if (mem_ready) begin
                e_ready = NREQ'(1) << m_owner;
                e_spo   = mem_spo;
            end else if (m_age == TO) begin
                e_ready = NREQ'(1) << m_owner;
                e_spo   = 32'hFFFF_FFFF;
                e_err   = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        int w;
        if (!rst) begin
            m_owner = -1; m_age = 0; m_last = NREQ - 1;
        end else if (m_owner >= 0) begin
            if (mem_ready || m_age == TO) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else begin
            w = pick_winner();
            if (w >= 0) begin
                m_owner = w;
                m_age   = 0;
            end
        end
    endtask

    task automatic at_sample();
        @(negedge clk);
        model_expect();
    endtask

    task automatic at_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_port(input int i, input logic [31:0] a, input logic [31:0] d,
                            input logic we, input logic rd);
        logic [NREQ*32-1:0] m, ta, td;
        logic [NREQ-1:0]    b;
        m = '0; m[31:0] = '1; m = m << (i * 32);
        ta = '0; ta[31:0] = a; ta = ta << (i * 32);
        td = '0; td[31:0] = d; td = td << (i * 32);
        b = NREQ'(1) << i;
        req_a  = (req_a & ~m) | ta;
        req_d  = (req_d & ~m) | td;
        req_we = (req_we & ~b) | (we ? b : '0);
        req_rd = (req_rd & ~b) | (rd ? b : '0);
    endtask

    task automatic drop(input int i);
        req_we = req_we & ~(NREQ'(1) << i);
        req_rd = req_rd & ~(NREQ'(1) << i);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        at_edge();
        rst = 1'b1;
    endtask

    task automatic drain();
        mem_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            at_sample();
            at_edge();
            for (int i = 0; i < NREQ; i++) if (bit_at(e_ready, i)) drop(i);
            if ((req_rd | req_we) == '0 && m_owner < 0) break;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        at_edge();
        at_edge();
        at_sample();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        total++; if ({mem_we, mem_rd, err} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {mem_we, mem_rd, err}); end
        total++; if (req_spo !== 32'h0) begin bad++; $display("FAIL reset_spo: got %h want 0", req_spo); end
        at_edge();
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        int t_ready;
        int pulses;
        t_ready = -1;
        pulses  = 0;
        set_port(1, 32'h2000_0010, 32'h0, 1'b0, 1'b1);
        mem_spo = 32'hDEAD_BEEF;
        for (int c = 0; c < 20; c++) begin
            mem_ready = (m_owner == 1 && m_age == 4);
            at_sample();
            if (c == 1) begin
                total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL rd_issue_strobe: got %b want 1", mem_rd); end
                total++; if (mem_a !== 32'h2000_0010) begin bad++; $display("FAIL rd_issue_addr: got %h want 20000010", mem_a); end
            end
            if (req_ready !== '0) begin
                pulses++;
                if (t_ready < 0) begin
                    t_ready = c;
                    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL rd_ready_port: got %b want 010", req_ready); end
                    total++; if (req_spo !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", req_spo); end
                end
            end
            at_edge();
            if (t_ready == c) drop(1);
        end
        mem_ready = 1'b0;
        total++; if (t_ready != 5) begin bad++; $display("FAIL rd_latency: got %0d want 5", t_ready); end
        total++; if (pulses != 1) begin bad++; $display("FAIL rd_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_contention();
        int order[$];
        int exp_order[6];
        exp_order = '{0, 1, 2, 0, 1, 2};
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_port(i, 32'h1000_0000 + 32'(i * 16), 32'(i), 1'b0, 1'b1);
        mem_ready = 1'b1;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            mem_spo = $urandom;
            at_sample();
            if (req_ready !== '0) begin
                order.push_back(onehot_idx(req_ready));
                total++; if (req_spo !== mem_spo) begin bad++; $display("FAIL cont_data: got %h want %h", req_spo, mem_spo); end
            end
            at_edge();
        end
        req_rd = '0;
        mem_ready = 1'b0;
        at_edge();
        total++; if (order.size() != 6) begin bad++; $display("FAIL cont_count: got %0d want 6", order.size()); end
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            total++; if (order[k] != exp_order[k]) begin bad++; $display("FAIL cont_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]); end
        end
    endtask

    task automatic test_lock();
        int  order[$];
        int  exp_order[5];
        bit  primed;
        exp_order = '{2, 2, 2, 2, 0};
        primed = 1'b0;
        reset_dut();
        set_port(1, 32'h3000_0000, 32'h0, 1'b0, 1'b1);
        mem_ready = 1'b1;
        for (int c = 0; c < 10 && !primed; c++) begin
            at_sample();
            if (bit_at(e_ready, 1)) primed = 1'b1;
            at_edge();
        end
        drop(1);
        set_port(0, 32'h3000_0100, 32'h55, 1'b1, 1'b0);
        set_port(2, 32'h3000_0200, 32'h0, 1'b0, 1'b1);
        lock = 3'b100;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            at_sample();
            if (req_ready !== '0) order.push_back(onehot_idx(req_ready));
            at_edge();
            if (order.size() >= 4) lock = '0;
        end
        req_rd = '0; req_we = '0; lock = '0; mem_ready = 1'b0;
        at_edge();
        total++; if (order.size() != 5) begin bad++; $display("FAIL lock_count: got %0d want 5", order.size()); end
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            total++; if (order[k] != exp_order[k]) begin bad++; $display("FAIL lock_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]); end
        end
    endtask

    task automatic test_timeout();
        int t_ready;
        int errs;
        t_ready = -1;
        errs    = 0;
        set_port(0, 32'h4000_0000, 32'hCAFE_F00D, 1'b1, 1'b0);
        mem_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            at_sample();
            if (err === 1'b1) errs++;
            if (c == 1) begin
                total++; if (mem_we !== 1'b1 || mem_d !== 32'hCAFE_F00D) begin bad++; $display("FAIL to_issue: got we=%b d=%h want we=1 d=cafef00d", mem_we, mem_d); end
            end
            if (t_ready >= 0 && c == t_ready + 1) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy_after: got %b want 0", busy); end
            end
            if (req_ready !== '0 && t_ready < 0) begin
                t_ready = c;
                total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL to_ready_port: got %b want 001", req_ready); end
                total++; if (req_spo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL to_data: got %h want ffffffff", req_spo); end
                total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err); end
            end
            at_edge();
            if (t_ready == c) drop(0);
            if (t_ready >= 0 && c >= t_ready + 1) break;
        end
        total++; if (t_ready != 17) begin bad++; $display("FAIL to_latency: got %0d want 17", t_ready); end
        total++; if (errs != 1) begin bad++; $display("FAIL to_err_pulses: got %0d want 1", errs); end
    endtask

    task automatic test_reset_mid_wait();
        set_port(1, 32'h5000_0000, 32'h0, 1'b0, 1'b1);
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            at_sample();
            at_edge();
        end
        rst = 1'b0;
        at_sample();
        total++; if (req_ready !== '0) begin bad++; $display("FAIL rmw_ready_in_reset: got %b want 000", req_ready); end
        at_edge();
        rst = 1'b1;
        set_port(0, 32'h5000_0100, 32'h77, 1'b1, 1'b0);
        at_sample();
        total++; if (mem_rd !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rmw_strobes: got rd=%b we=%b want 0 0", mem_rd, mem_we); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL rmw_ready: got %b want 000", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_busy: got %b want 0", busy); end
        at_edge();
        at_sample();
        total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL rmw_regrant: got busy=%b id=%0d want 1 0", busy, grant_id); end
        at_edge();
        drain();
    endtask

    task automatic test_tc_edge();
        bit done;
        done = 1'b0;
        set_port(2, 32'h6000_0000, 32'h0, 1'b0, 1'b1);
        mem_spo = 32'h1234_5678;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ready = (m_owner == 2 && m_age == TO);
            at_sample();
            if (req_ready !== '0) begin
                done = 1'b1;
                total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL tc_ready_port: got %b want 100", req_ready); end
                total++; if (err !== 1'b0) begin bad++; $display("FAIL tc_err: got %b want 0", err); end
                total++; if (req_spo !== 32'h1234_5678) begin bad++; $display("FAIL tc_data: got %h want 12345678", req_spo); end
                total++; if (c != 17) begin bad++; $display("FAIL tc_latency: got %0d want 17", c); end
            end
            at_edge();
            if (done) drop(2);
        end
        mem_ready = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL tc_no_completion: got none want one within 40 cycles"); end
    endtask

    task automatic test_random();
        bit pending[NREQ];
        int kind;
        for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) begin
                    kind = int'($urandom_range(0, 2));
                    set_port(i, $urandom, $urandom, kind != 0, kind != 1);
                    pending[i] = 1'b1;
                end
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_spo   = $urandom;
            if ($urandom_range(0, 15) == 0) lock = NREQ'($urandom_range(0, 7));
            at_sample();
            total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, e_ready); end
            total++; if (req_spo !== e_spo) begin bad++; $display("FAIL rnd_spo c=%0d: got %h want %h", c, req_spo, e_spo); end
            total++; if (mem_we !== e_we || mem_rd !== e_rd) begin bad++; $display("FAIL rnd_strobes c=%0d: got we=%b rd=%b want we=%b rd=%b", c, mem_we, mem_rd, e_we, e_rd); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, e_busy); end
            total++; if (err !== e_err) begin bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err, e_err); end
            if (e_busy) begin
                total++; if (grant_id !== 2'(m_owner)) begin bad++; $display("FAIL rnd_grant c=%0d: got %0d want %0d", c, grant_id, m_owner); end
                total++; if (mem_a !== e_a || mem_d !== e_d) begin bad++; $display("FAIL rnd_bus c=%0d: got a=%h d=%h want a=%h d=%h", c, mem_a, mem_d, e_a, e_d); end
            end
            at_edge();
            for (int i = 0; i < NREQ; i++) begin
                if (bit_at(e_ready, i)) begin
                    if ($urandom_range(0, 1) == 0) begin
                        kind = int'($urandom_range(0, 2));
                        set_port(i, $urandom, $urandom, kind != 0, kind != 1);
                    end else begin
                        drop(i);
                        pending[i] = 1'b0;
                    end
                end
            end
        end
        lock = '0;
        drain();
    endtask

    initial begin
        m_owner = -1; m_age = 0; m_last = NREQ - 1;
        rst = 1'b0; req_a = '0; req_d = '0; req_we = '0; req_rd = '0;
        lock = '0; mem_ready = 1'b0; mem_spo = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_timeout();
        test_reset_mid_wait();
        test_tc_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
